// File: rtl/proc_status.sv
`default_nettype none
// ============================================================================
// Module   : proc_status
// Purpose  : MOS 6502 processor status register P = {N,V,1,B,D,I,Z,C}.
//            Captures ALU flag results, handles BIT, PLP/RTI, flag set/clear
//            instructions, interrupt entry and the delayed IRQ mask.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  core clock, rising-edge updates
//   reset          in   1  asynchronous active-high reset
//   alu_Y          in   8  ALU result (source of N, Z)
//   alu_carry_out  in   1  ALU carry (source of C)
//   alu_overflow   in   1  ALU overflow (source of V)
//   mem_data       in   8  data-bus byte (BIT operand / pulled P)
//   p_op           in   3  0 NOP,1 ALU,2 BIT,3 PLP,4 SETF,5 CLRF,6 INT,7 NOP
//   flag_we        in   4  ALU write enables {N,V,Z,C}
//   flag_sel       in   3  bit index for SETF/CLRF
//   push_brk       in   1  B value placed in p_push
//   instr_done     in   1  last-cycle-of-instruction pulse
//   p_reg          out  8  current P
//   p_push         out  8  P as pushed to the stack
//   carry_flag     out  1  C, to alu_carry_in
//   decimal_flag   out  1  D, to the decimal path
//   irq_mask       out  1  delayed I used by the interrupt poller
// ============================================================================
module proc_status #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic [7:0] mem_data,
  input  logic [2:0] p_op,
  input  logic [3:0] flag_we,
  input  logic [2:0] flag_sel,
  input  logic       push_brk,
  input  logic       instr_done,
  output logic [7:0] p_reg,
  output logic [7:0] p_push,
  output logic       carry_flag,
  output logic       decimal_flag,
  output logic       irq_mask
);

  // Operation encoding
  localparam logic [2:0] C_OP_NOP  = 3'd0;
  localparam logic [2:0] C_OP_ALU  = 3'd1;
  localparam logic [2:0] C_OP_BIT  = 3'd2;
  localparam logic [2:0] C_OP_PLP  = 3'd3;
  localparam logic [2:0] C_OP_SETF = 3'd4;
  localparam logic [2:0] C_OP_CLRF = 3'd5;
  localparam logic [2:0] C_OP_INT  = 3'd6;

  // Bit positions inside P
  localparam int C_BIT_C = 0;
  localparam int C_BIT_Z = 1;
  localparam int C_BIT_I = 2;
  localparam int C_BIT_D = 3;
  localparam int C_BIT_V = 6;
  localparam int C_BIT_N = 7;

  // Bit5 is hard-wired 1 and bit4 (B) does not exist in the register.
  localparam logic [7:0] C_FORCE_ONE  = 8'h20;
  localparam logic [7:0] C_FORCE_ZERO = 8'h10;
  localparam logic [7:0] C_RESET_VAL  = (RESET_P | C_FORCE_ONE) & ~C_FORCE_ZERO;

  logic [7:0] r_p;
  logic       r_irq_mask;
  logic [7:0] w_p_raw;
  logic [7:0] w_p_next;
  logic       w_alu_zero;
  logic       w_setf_legal;
  logic       w_clrf_legal;

  assign w_alu_zero = (alu_Y == 8'h00);

  // SETF is only defined for C, I, D; CLRF additionally for V (CLV).
  assign w_setf_legal = (flag_sel == 3'd0) || (flag_sel == 3'd2) || (flag_sel == 3'd3);
  assign w_clrf_legal = w_setf_legal || (flag_sel == 3'd6);

  always_comb begin
    w_p_raw = r_p;
    case (p_op)
      C_OP_ALU: begin
        if (flag_we[3]) w_p_raw[C_BIT_N] = alu_Y[7];
        if (flag_we[2]) w_p_raw[C_BIT_V] = alu_overflow;
        if (flag_we[1]) w_p_raw[C_BIT_Z] = w_alu_zero;
        if (flag_we[0]) w_p_raw[C_BIT_C] = alu_carry_out;
      end
      C_OP_BIT: begin
        // N/V come straight from the operand; Z from the ALU's A AND M.
        w_p_raw[C_BIT_N] = mem_data[7];
        w_p_raw[C_BIT_V] = mem_data[6];
        w_p_raw[C_BIT_Z] = w_alu_zero;
      end
      C_OP_PLP: begin
        w_p_raw = mem_data;
      end
      C_OP_SETF: begin
        if (w_setf_legal) w_p_raw[flag_sel] = 1'b1;
      end
      C_OP_CLRF: begin
        if (w_clrf_legal) w_p_raw[flag_sel] = 1'b0;
      end
      C_OP_INT: begin
        // NMOS part: D is not cleared on interrupt entry.
        w_p_raw[C_BIT_I] = 1'b1;
      end
      default: begin
        // NOP and reserved encoding: hold.
      end
    endcase
    w_p_next = (w_p_raw | C_FORCE_ONE) & ~C_FORCE_ZERO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p <= C_RESET_VAL;
    end else begin
      r_p <= w_p_next;
    end
  end

  // The mask samples the pre-update I, so CLI/SEI/PLP take effect one
  // instruction late. Interrupt entry closes the window immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask <= RESET_P[2];
    end else if (p_op == C_OP_INT) begin
      r_irq_mask <= 1'b1;
    end else if (instr_done) begin
      r_irq_mask <= r_p[C_BIT_I];
    end
  end

  assign p_reg        = r_p;
  assign p_push       = {r_p[7:6], 1'b1, push_brk, r_p[3:0]};
  assign carry_flag   = r_p[C_BIT_C];
  assign decimal_flag = r_p[C_BIT_D];
  assign irq_mask     = r_irq_mask;

  // NOP encoding named for readability of the decode table only.
  logic w_unused;
  assign w_unused = (C_OP_NOP == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_proc_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_status
// Purpose  : Directed self-checking bench for proc_status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_status;

  logic       clk;
  logic       reset;
  logic [7:0] alu_Y;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic [7:0] mem_data;
  logic [2:0] p_op;
  logic [3:0] flag_we;
  logic [2:0] flag_sel;
  logic       push_brk;
  logic       instr_done;
  logic [7:0] p_reg;
  logic [7:0] p_push;
  logic       carry_flag;
  logic       decimal_flag;
  logic       irq_mask;

  int vectors;
  int miscompares;

  proc_status #(.RESET_P(8'h24)) dut (
    .clk(clk), .reset(reset), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
    .alu_overflow(alu_overflow), .mem_data(mem_data), .p_op(p_op),
    .flag_we(flag_we), .flag_sel(flag_sel), .push_brk(push_brk),
    .instr_done(instr_done), .p_reg(p_reg), .p_push(p_push),
    .carry_flag(carry_flag), .decimal_flag(decimal_flag), .irq_mask(irq_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of stimulus, let the edge happen, return idle inputs.
  task automatic drive(input logic [2:0] op, input logic [3:0] we, input logic [2:0] sel,
                       input logic [7:0] y, input logic co, input logic ov,
                       input logic [7:0] mem, input logic done);
    p_op = op; flag_we = we; flag_sel = sel; alu_Y = y;
    alu_carry_out = co; alu_overflow = ov; mem_data = mem; instr_done = done;
    @(posedge clk);
    #1;
    p_op = 3'd0; flag_we = 4'd0; instr_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; push_brk = 1'b1;
    #2;
    vectors++;
    if (p_reg !== 8'h24) begin miscompares++; $display("FAIL reset_p: got %h want %h", p_reg, 8'h24); end
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL reset_mask: got %b want 1", irq_mask); end
    vectors++;
    if (p_push !== 8'h34) begin miscompares++; $display("FAIL reset_push: got %h want %h", p_push, 8'h34); end
    push_brk = 1'b0;
    #1;
    vectors++;
    if (p_push !== 8'h24) begin miscompares++; $display("FAIL reset_push_irq: got %h want %h", p_push, 8'h24); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu;
    drive(3'd1, 4'b1111, 3'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'h67) begin miscompares++; $display("FAIL alu_all: got %h want %h", p_reg, 8'h67); end
    vectors++;
    if (carry_flag !== 1'b1) begin miscompares++; $display("FAIL alu_carry1: got %b want 1", carry_flag); end
    drive(3'd1, 4'b1001, 3'd0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'he6) begin miscompares++; $display("FAIL alu_partial: got %h want %h", p_reg, 8'he6); end
    vectors++;
    if (carry_flag !== 1'b0) begin miscompares++; $display("FAIL alu_carry0: got %b want 0", carry_flag); end
    drive(3'd1, 4'b0000, 3'd0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'he6) begin miscompares++; $display("FAIL alu_noop: got %h want %h", p_reg, 8'he6); end
    push_brk = 1'b1; #1;
    vectors++;
    if (p_push !== 8'hf6) begin miscompares++; $display("FAIL push_brk: got %h want %h", p_push, 8'hf6); end
    push_brk = 1'b0; #1;
    vectors++;
    if (p_push !== 8'he6) begin miscompares++; $display("FAIL push_irq: got %h want %h", p_push, 8'he6); end
  endtask

  task automatic test_bit;
    drive(3'd3, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b0);
    vectors++;
    if (p_reg !== 8'h29) begin miscompares++; $display("FAIL bit_setup: got %h want %h", p_reg, 8'h29); end
    drive(3'd2, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'hc0, 1'b0);
    vectors++;
    if (p_reg !== 8'heb) begin miscompares++; $display("FAIL bit_set: got %h want %h", p_reg, 8'heb); end
    drive(3'd2, 4'd0, 3'd0, 8'h01, 1'b0, 1'b1, 8'h3f, 1'b0);
    vectors++;
    if (p_reg !== 8'h29) begin miscompares++; $display("FAIL bit_clr: got %h want %h", p_reg, 8'h29); end
    vectors++;
    if (decimal_flag !== 1'b1) begin miscompares++; $display("FAIL bit_dhold: got %b want 1", decimal_flag); end
  endtask

  task automatic test_plp;
    drive(3'd3, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'hff, 1'b0);
    vectors++;
    if (p_reg !== 8'hef) begin miscompares++; $display("FAIL plp_ff: got %h want %h", p_reg, 8'hef); end
    drive(3'd3, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'h20) begin miscompares++; $display("FAIL plp_00: got %h want %h", p_reg, 8'h20); end
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL plp_mask_hold: got %b want 1", irq_mask); end
  endtask

  task automatic test_setclr;
    logic [2:0] bad_set [4];
    logic [7:0] exp_clr [4];
    logic [2:0] sel_clr [4];
    bad_set = '{3'd1, 3'd4, 3'd5, 3'd6};
    drive(3'd4, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(3'd4, 4'd0, 3'd2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(3'd4, 4'd0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'h2d) begin miscompares++; $display("FAIL setf_legal: got %h want %h", p_reg, 8'h2d); end
    for (int i = 0; i < 4; i++) begin
      drive(3'd4, 4'd0, bad_set[i], 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      vectors++;
      if (p_reg !== 8'h2d) begin miscompares++; $display("FAIL setf_illegal_%0d: got %h want %h", bad_set[i], p_reg, 8'h2d); end
    end
    drive(3'd3, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'hed, 1'b0);
    drive(3'd5, 4'd0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (p_reg !== 8'hed) begin miscompares++; $display("FAIL clrf_illegal_7: got %h want %h", p_reg, 8'hed); end
    sel_clr = '{3'd6, 3'd0, 3'd3, 3'd2};
    exp_clr = '{8'had, 8'hac, 8'ha4, 8'ha0};
    for (int i = 0; i < 4; i++) begin
      drive(3'd5, 4'd0, sel_clr[i], 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      vectors++;
      if (p_reg !== exp_clr[i]) begin miscompares++; $display("FAIL clrf_%0d: got %h want %h", sel_clr[i], p_reg, exp_clr[i]); end
    end
  endtask

  task automatic test_mask_delay;
    drive(3'd4, 4'd0, 3'd2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // SEI, no boundary
    drive(3'd0, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);   // boundary: mask <= 1
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL mask_setup: got %b want 1", irq_mask); end
    drive(3'd5, 4'd0, 3'd2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);   // CLI at boundary
    vectors++;
    if (p_reg !== 8'ha0) begin miscompares++; $display("FAIL cli_p: got %h want %h", p_reg, 8'ha0); end
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL cli_mask_late: got %b want 1", irq_mask); end
    drive(3'd0, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (irq_mask !== 1'b0) begin miscompares++; $display("FAIL cli_mask_next: got %b want 0", irq_mask); end
    drive(3'd4, 4'd0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // SED
    drive(3'd6, 4'd0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);   // interrupt entry
    vectors++;
    if (p_reg !== 8'hac) begin miscompares++; $display("FAIL int_p: got %h want %h", p_reg, 8'hac); end
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL int_mask: got %b want 1", irq_mask); end
    drive(3'd7, 4'b1111, 3'd0, 8'h00, 1'b0, 1'b1, 8'hff, 1'b0);
    vectors++;
    if (p_reg !== 8'hac) begin miscompares++; $display("FAIL op7_nop: got %h want %h", p_reg, 8'hac); end
  endtask

  task automatic test_midreset;
    // PLP pending when reset arrives mid-cycle: it must be lost.
    p_op = 3'd3; mem_data = 8'hc3; instr_done = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (p_reg !== 8'h24) begin miscompares++; $display("FAIL midreset_p: got %h want %h", p_reg, 8'h24); end
    @(posedge clk); #1;
    vectors++;
    if (p_reg !== 8'h24) begin miscompares++; $display("FAIL midreset_hold: got %h want %h", p_reg, 8'h24); end
    vectors++;
    if (irq_mask !== 1'b1) begin miscompares++; $display("FAIL midreset_mask: got %b want 1", irq_mask); end
    p_op = 3'd0; instr_done = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    p_op = 3'd0; flag_we = 4'd0; flag_sel = 3'd0; alu_Y = 8'h00;
    alu_carry_out = 1'b0; alu_overflow = 1'b0; mem_data = 8'h00;
    instr_done = 1'b0; push_brk = 1'b0; reset = 1'b0;
    test_reset;
    test_alu;
    test_bit;
    test_plp;
    test_setclr;
    test_mask_delay;
    test_midreset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
